// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state encoding for the UART receiver
//
// Purpose: bit-rate presets, 8N1 frame constants and the receiver state type.
// Ports:   none (package).

package uart_pkg;

  // Clock cycles per bit for a 100 MHz system clock.
  localparam int CLKS_PER_BIT_115200 = 868;
  localparam int CLKS_PER_BIT_9600   = 10417;

  // 8N1 frame layout.
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - two-flop synchronizer for the asynchronous serial line
//
// Purpose: bring rx into the clk domain; both flops reset to the idle level 1.
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous active-high reset
//   d   - asynchronous input
//   q   - synchronized output

module bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with framing-error detection
//
// Purpose: oversample a synchronized serial line, assemble 8N1 frames and
//          report each byte or framing error with a one-cycle pulse.
// Ports:
//   clk       - system clock, rising edge
//   rst       - synchronous active-high reset
//   rx        - asynchronous serial input, idle high
//   rx_data   - last correctly received byte
//   rx_valid  - one-cycle pulse when rx_data is updated
//   frame_err - one-cycle pulse when the stop bit is sampled low
//   busy      - high whenever the receiver is not in IDLE

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
    $error("uart_rx: CLKS_PER_BIT must be 4 or more");
  end

  if (STOP_BITS != 1) begin : g_bad_stop_bits
    $error("uart_rx: only one stop bit is supported");
  end

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  bit_sync u_bit_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [IDX_W-1:0]     bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic [DATA_BITS-1:0] rx_data_next;
  logic                 rx_valid_next;
  logic                 frame_err_next;

  // The synchronizer flops reset to 1, so right after reset rx_s shows a
  // high that the line never produced. settle marks when the synchronizer
  // has been refilled from the real line; armed then requires one genuine
  // high before IDLE may accept a start bit, so a line that is already low
  // when reset drops can never be mistaken for a falling edge.
  logic [1:0]           settle;
  logic                 armed, armed_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      settle    <= 2'b00;
      armed     <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bit_idx   <= bit_idx_next;
      shift     <= shift_next;
      rx_data   <= rx_data_next;
      rx_valid  <= rx_valid_next;
      frame_err <= frame_err_next;
      settle    <= {settle[0], 1'b1};
      armed     <= armed_next;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    bit_idx_next   = bit_idx;
    shift_next     = shift;
    rx_data_next   = rx_data;
    rx_valid_next  = 1'b0;
    frame_err_next = 1'b0;
    armed_next     = armed | (settle[1] & rx_s);

    case (state)
      IDLE: begin
        if (armed && !rx_s) begin
          cnt_next   = '0;
          state_next = START;
        end
      end

      // Re-check the start bit at its middle; a high here was a glitch.
      START: begin
        if (cnt == CNT_HALF) begin
          if (!rx_s) begin
            cnt_next   = '0;
            state_next = DATA;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      // Sampling one full bit-time after the start midpoint lands each
      // sample in the middle of its data bit.
      DATA: begin
        if (cnt == CNT_LAST) begin
          shift_next[bit_idx] = rx_s;
          cnt_next            = '0;
          if (bit_idx == IDX_LAST) begin
            bit_idx_next = '0;
            state_next   = STOP;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            rx_data_next  = shift;
            rx_valid_next = 1'b1;
            state_next    = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = WAIT_HIGH;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      // A held-low line (break) must return high before any new frame.
      WAIT_HIGH: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule
